// File: rtl/pulse_handshake_tx.sv
// Four-phase request transmitter, one independent channel per bit: a clk-domain
// pulse becomes a held request level that returns to zero after the far side acks.
module pulse_handshake_tx #(
    parameter int Width    = 1,
    parameter int Min_High = 4
) (
    input  logic               clk,
    input  logic               sres,
    input  logic [Width-1:0]   Pulse_In,
    input  logic [Width-1:0]   Ack_Async,
    output logic [Width-1:0]   Req_Out,
    output logic [Width-1:0]   Busy,
    output logic [Width-1:0]   Done_d,
    output logic [Width-1:0]   Overrun_d,
    output logic [2*Width-1:0] dbg_state,
    output logic [Width-1:0]   dbg_pending
);
    localparam int CntW = (Min_High > 1) ? $clog2(Min_High) : 1;
    localparam logic [CntW-1:0] HoldMax = CntW'(Min_High - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACKLOW = 2'd2
    } state_e;

    for (genvar i = 0; i < Width; i++) begin : g_bit
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            pending_q, pending_d;
        logic            ack_meta_q, ack_s_q;
        logic            req_q, req_d;
        logic            busy_q, busy_d;
        logic            done_q, done_d;
        logic            ovr_q, ovr_d;
        logic            pulse;
        logic            hold_met;

        assign pulse    = Pulse_In[i];
        assign hold_met = (cnt_q == HoldMax);

        always_comb begin
            state_d   = state_q;
            pending_d = pending_q;
            done_d    = 1'b0;
            ovr_d     = 1'b0;
            cnt_d     = '0;

            case (state_q)
                S_IDLE: begin
                    if (pulse) state_d = S_REQ;
                end
                S_REQ: begin
                    if (ack_s_q && hold_met) state_d = S_ACKLOW;
                    if (pulse) begin
                        if (pending_q) ovr_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end
                S_ACKLOW: begin
                    if (!ack_s_q) begin
                        done_d  = 1'b1;
                        state_d = (pending_q || pulse) ? S_REQ : S_IDLE;
                        // A pulse arriving on the exit edge takes the slot the
                        // consumed pending event just freed, so it is not an overrun.
                        pending_d = pending_q && pulse;
                    end else if (pulse) begin
                        if (pending_q) ovr_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Hold counter restarts from zero on every REQ entry.
            if (state_q == S_REQ && state_d == S_REQ) begin
                cnt_d = hold_met ? cnt_q : cnt_q + 1'b1;
            end

            req_d  = (state_d == S_REQ);
            busy_d = (state_d != S_IDLE) || pending_d;
        end

        always_ff @(posedge clk) begin
            if (sres) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                pending_q  <= 1'b0;
                ack_meta_q <= 1'b0;
                ack_s_q    <= 1'b0;
                req_q      <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                ovr_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                pending_q  <= pending_d;
                ack_meta_q <= Ack_Async[i];
                ack_s_q    <= ack_meta_q;
                req_q      <= req_d;
                busy_q     <= busy_d;
                done_q     <= done_d;
                ovr_q      <= ovr_d;
            end
        end

        assign Req_Out[i]          = req_q;
        assign Busy[i]             = busy_q;
        assign Done_d[i]           = done_q;
        assign Overrun_d[i]        = ovr_q;
        assign dbg_state[2*i +: 2] = state_q;
        assign dbg_pending[i]      = pending_q;
    end

endmodule
